// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. A round-robin
//   arbiter picks one valid request, registers its operands onto the ALU
//   pins, enables the ALU for exactly one cycle, then captures the result and
//   flags. They are returned on a single response channel that is tagged with
//   the id of the requester that issued the op.
//   Sequence per operation: IDLE (accept) -> EXEC (ALU enabled) -> RESP (hold
//   the response until it is taken) -> IDLE.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req0_valid / req0_ready requester 0 handshake (ready only in IDLE)
//   req0_a, req0_b          requester 0 operands
//   req0_funct              requester 0 function select
//   req1_*                  same set for requester 1
//   rsp_valid / rsp_ready   response handshake
//   rsp_id                  requester that issued the op (0/1)
//   rsp_out, rsp_flags      captured ALU result and flags
//   alu_A, alu_B, alu_funct registered operands driven to the ALU
//   alu_enable              high only during the single EXEC cycle
//   alu_out, alu_flags      combinational result returned by the ALU
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6,
  parameter int FLAG_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [FUNCT_W-1:0] req0_funct,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [FUNCT_W-1:0] req1_funct,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_out,
  output logic [FLAG_W-1:0]  rsp_flags,
  output logic [WIDTH-1:0]   alu_A,
  output logic [WIDTH-1:0]   alu_B,
  output logic [FUNCT_W-1:0] alu_funct,
  output logic               alu_enable,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [FLAG_W-1:0]  alu_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   id;
  logic   grant;
  logic   accept;

  // On a tie the requester that did not win last time is chosen; otherwise
  // the single valid requester wins. With no valid requester grant is unused.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Acceptance happens only in IDLE and never depends on rsp_ready.
  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // Decoded straight from the state register, so it is glitch-free.
  assign alu_enable = (state == EXEC);

  // Main sequencer: operand capture, ALU result capture and response hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_funct  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_out    <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_A      <= grant ? req1_a : req0_a;
            alu_B      <= grant ? req1_b : req0_b;
            alu_funct  <= grant ? req1_funct : req0_funct;
            last_grant <= grant;
            id         <= grant;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_out   <= alu_out;
          rsp_flags <= alu_flags;
          rsp_id    <= id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
